// File: rtl/conv_maxpool_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : conv_maxpool_if
// Brief    : Input/output stream handshake bundle for conv_maxpool.
// Revision : 1.0 - initial release
// ============================================================================
interface conv_maxpool_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          frame_done;

  modport mst (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, frame_done
  );

  modport slv (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/conv_maxpool.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : conv_maxpool
// Brief    : 2x2 stride-2 signed max pooling of a raster-order DIMxDIM map.
//            Define CONV_MAXPOOL_RELU_EN to clamp negative inputs to zero.
// Revision : 1.0 - initial release
// ============================================================================
module conv_maxpool #(
  parameter int DIM = 8,
  parameter int DW  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  conv_maxpool_if.slv   bus
);

  localparam int CW   = $clog2(DIM);
  localparam int HALF = DIM / 2;
  localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [CW-1:0] c_LAST     = CW'(DIM - 1);
  localparam logic [CW:0]   c_EDGE     = (CW+1)'(2 * HALF);
  localparam logic [CW-1:0] c_WIN_LAST = CW'(2 * HALF - 1);

  logic [CW-1:0]          r_col;
  logic [CW-1:0]          r_row;
  logic signed [DW-1:0]   r_pair;
  logic signed [DW-1:0]   r_rowbuf [0:(1<<HW)-1];
  logic                   r_out_valid;
  logic signed [DW-1:0]   r_out_data;
  logic                   r_out_last;

  logic                   w_accept;
  logic signed [DW-1:0]   w_raw;
  logic signed [DW-1:0]   w_x;
  logic signed [DW-1:0]   w_pair_max;
  logic signed [DW-1:0]   w_result;
  logic [HW-1:0]          w_idx;
  logic                   w_in_win;
  logic                   w_load;
  logic                   w_last_win;

  assign bus.in_ready   = ~r_out_valid | bus.out_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.frame_done = r_out_valid & bus.out_ready & r_out_last;

  assign w_accept = bus.in_valid & bus.in_ready;
  assign w_raw    = bus.in_data;

`ifdef CONV_MAXPOOL_RELU_EN
  assign w_x = w_raw[DW-1] ? '0 : w_raw;
`else
  assign w_x = w_raw;
`endif

  // Trailing row/column of an odd-sized map fall outside every window.
  assign w_in_win   = ({1'b0, r_row} < c_EDGE) && ({1'b0, r_col} < c_EDGE);
  assign w_idx      = HW'(r_col >> 1);
  assign w_pair_max = (w_x > r_pair) ? w_x : r_pair;
  assign w_result   = (r_rowbuf[w_idx] > w_pair_max) ? r_rowbuf[w_idx] : w_pair_max;
  assign w_load     = w_accept && w_in_win && r_row[0] && r_col[0];
  assign w_last_win = (r_row == c_WIN_LAST) && (r_col == c_WIN_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (r_col == c_LAST) begin
        r_col <= '0;
        r_row <= (r_row == c_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pair <= '0;
    end else if (w_accept && w_in_win && !r_col[0]) begin
      r_pair <= w_x;
    end
  end

  // Row buffer holds the horizontal pair maxima of the pending even row.
  always_ff @(posedge clk) begin
    if (w_accept && w_in_win && !r_row[0] && r_col[0]) begin
      r_rowbuf[w_idx] <= w_pair_max;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_result;
      r_out_last  <= w_last_win;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_maxpool.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_conv_maxpool
// Brief    : Table-driven scoreboard bench for conv_maxpool (DIM=4 and DIM=5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_maxpool;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_maxpool_if #(.DW(DW)) bus4 ();
  conv_maxpool_if #(.DW(DW)) bus5 ();

  conv_maxpool #(.DIM(4), .DW(DW)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  conv_maxpool #(.DIM(5), .DW(DW)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

  typedef struct {
    int sel;
    int base;
    bit neg;
    int stall;
    bit strict;
    int exp[4];
  } vec_t;

  typedef struct {
    int data;
    bit last;
  } exp_t;

  vec_t vecs[4];
  int   stim_q[$];
  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic set_in(input int sel, input logic v, input logic [31:0] d, input logic r);
    if (sel == 0) begin
      bus4.in_valid = v; bus4.in_data = d; bus4.out_ready = r;
    end else begin
      bus5.in_valid = v; bus5.in_data = d; bus5.out_ready = r;
    end
  endtask

  task automatic get_out(input int sel, output logic ov, output logic [31:0] od,
                         output logic fd, output logic ir);
    if (sel == 0) begin
      ov = bus4.out_valid; od = bus4.out_data; fd = bus4.frame_done; ir = bus4.in_ready;
    end else begin
      ov = bus5.out_valid; od = bus5.out_data; fd = bus5.frame_done; ir = bus5.in_ready;
    end
  endtask

  task automatic set_vec(input int i, input int sel, input int base, input bit neg,
                         input int stall, input bit strict,
                         input int e0, input int e1, input int e2, input int e3);
    vecs[i].sel = sel; vecs[i].base = base; vecs[i].neg = neg;
    vecs[i].stall = stall; vecs[i].strict = strict;
    vecs[i].exp[0] = e0; vecs[i].exp[1] = e1; vecs[i].exp[2] = e2; vecs[i].exp[3] = e3;
  endtask

  task automatic push_exp(input int d, input bit last);
    exp_t e;
    e.data = d;
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Streams stim_q into the selected DUT, scoring outputs against exp_q.
  task automatic run(input int sel, input int stall, input bit strict, input string tag);
    int   idx = 0;
    int   cyc = 0;
    int   stall_left = stall;
    logic ov, fd, ir, orr;
    logic [31:0] od;
    exp_t e;
    while ((idx < stim_q.size() || exp_q.size() > 0) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      get_out(sel, ov, od, fd, ir);
      if (stall_left > 0 && ov) begin
        orr = 1'b0;
        stall_left--;
      end else begin
        orr = 1'b1;
      end
      set_in(sel, idx < stim_q.size(), (idx < stim_q.size()) ? stim_q[idx] : 0, orr);
      #1;
      get_out(sel, ov, od, fd, ir);
      if (ov && !orr) begin
        check({tag, " stall in_ready"}, {31'd0, ir}, 0);
        if (exp_q.size() > 0) check({tag, " stall hold"}, od, exp_q[0].data);
      end else if (ov) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL %s unexpected output: got %0d, expected none", tag, $signed(od));
        end else begin
          e = exp_q.pop_front();
          check({tag, " out_data"}, od, e.data);
          check({tag, " frame_done"}, {31'd0, fd}, {31'd0, e.last});
        end
      end else begin
        check({tag, " idle frame_done"}, {31'd0, fd}, 0);
      end
      if (strict) check({tag, " in_ready"}, {31'd0, ir}, 1);
      if (idx < stim_q.size() && ir) idx++;
    end
    if (cyc >= 400) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: got %0d outputs pending, expected 0", tag, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    set_in(sel, 1'b0, 32'd0, 1'b1);
    stim_q.delete();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, " out_valid"},  {31'd0, bus4.out_valid},  0);
    check({tag, " out_data"},   bus4.out_data,            0);
    check({tag, " frame_done"}, {31'd0, bus4.frame_done}, 0);
    check({tag, " in_ready"},   {31'd0, bus4.in_ready},   1);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 1'b0, 32'd0, 1'b1);
    set_in(1, 1'b0, 32'd0, 1'b1);
    repeat (3) @(negedge clk);
    reset_checks("reset");
    check("reset dim5 out_valid", {31'd0, bus5.out_valid}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    set_vec(0, 0, 0, 1'b0, 0, 1'b1, 5, 7, 13, 15);
    set_vec(1, 0, 0, 1'b0, 6, 1'b0, 5, 7, 13, 15);
    set_vec(2, 1, 0, 1'b0, 0, 1'b1, 6, 8, 16, 18);
`ifdef CONV_MAXPOOL_RELU_EN
    set_vec(3, 0, 0, 1'b1, 0, 1'b1, 0, 0, 0, 0);
`else
    set_vec(3, 0, 0, 1'b1, 0, 1'b1, -1, -3, -3, -3);
`endif

    for (int v = 0; v < 4; v++) begin
      int n;
      n = (vecs[v].sel == 0) ? 16 : 25;
      for (int i = 0; i < n; i++) begin
        if (vecs[v].neg) stim_q.push_back((i == 5) ? -1 : -3);
        else             stim_q.push_back(vecs[v].base + i);
      end
      for (int j = 0; j < 4; j++) push_exp(vecs[v].exp[j], j == 3);
      run(vecs[v].sel, vecs[v].stall, vecs[v].strict, $sformatf("vec%0d", v));
      repeat (2) @(negedge clk);
    end

    // Reset mid-frame: the window completed by element 5 must never be seen.
    for (int i = 0; i < 6; i++) stim_q.push_back(i);
    run(0, 0, 1'b0, "pre-reset");
    rst_n = 1'b0;
    #1;
    reset_checks("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) stim_q.push_back(i);
    push_exp(5, 1'b0); push_exp(7, 1'b0); push_exp(13, 1'b0); push_exp(15, 1'b1);
    run(0, 0, 1'b1, "post-reset");
    repeat (2) @(negedge clk);

    // Two frames back to back with in_valid held high across the boundary.
    for (int i = 0; i < 16; i++) stim_q.push_back(i);
    for (int i = 0; i < 16; i++) stim_q.push_back(100 + i);
    push_exp(5, 1'b0);   push_exp(7, 1'b0);   push_exp(13, 1'b0);  push_exp(15, 1'b1);
    push_exp(105, 1'b0); push_exp(107, 1'b0); push_exp(113, 1'b0); push_exp(115, 1'b1);
    run(0, 0, 1'b1, "twoframe");
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
